// File: rtl/icache_refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_pkg
//  Purpose  : Shared defaults, metadata record and address helpers for the
//             I$ refill engine.
//  Revision : 1.0 - initial release
// ============================================================================
package icache_refill_pkg;

   localparam int unsigned DEF_LINE_WIDTH      = 128;
   localparam int unsigned DEF_BEAT_WIDTH      = 64;
   localparam int unsigned DEF_PADDR_WIDTH     = 56;
   localparam int unsigned DEF_AXI_ADDR_WIDTH  = 64;
   localparam int unsigned DEF_TID_WIDTH       = 2;
   localparam int unsigned DEF_AXI_ID_WIDTH    = 4;
   localparam int unsigned DEF_RD_TX_ID        = 0;
   localparam int unsigned DEF_MAX_OUTSTANDING = 2;

   typedef struct packed {
      logic [DEF_TID_WIDTH-1:0] tid;
      logic                     nc;
   } meta_t;

   function automatic int unsigned num_beats(input int unsigned line_width,
                                             input int unsigned beat_width);
      return line_width / beat_width;
   endfunction

   // Widths are powers of two, so alignment is a mask of the byte offset.
   function automatic logic [63:0] align_line(input logic [63:0]   addr,
                                              input int unsigned   line_width);
      return addr & ~(64'(line_width / 8) - 64'd1);
   endfunction

   function automatic logic [63:0] align_beat(input logic [63:0]   addr,
                                              input int unsigned   beat_width);
      return addr & ~(64'(beat_width / 8) - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl_if
//  Purpose  : Miss request, AXI AR/R and line return bundles of the refill
//             engine; master = refill engine, slave = cache/fabric side.
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if
   import icache_refill_pkg::*;
#(
   parameter int unsigned LINE_WIDTH     = DEF_LINE_WIDTH,
   parameter int unsigned BEAT_WIDTH     = DEF_BEAT_WIDTH,
   parameter int unsigned PADDR_WIDTH    = DEF_PADDR_WIDTH,
   parameter int unsigned AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
   parameter int unsigned TID_WIDTH      = DEF_TID_WIDTH,
   parameter int unsigned AXI_ID_WIDTH   = DEF_AXI_ID_WIDTH
) ();
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [PADDR_WIDTH-1:0]    req_paddr_i;
   logic                      req_nc_i;
   logic [TID_WIDTH-1:0]      req_tid_i;

   logic                      ar_valid_o;
   logic                      ar_ready_i;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_o;
   logic [7:0]                ar_len_o;
   logic [2:0]                ar_size_o;
   logic [AXI_ID_WIDTH-1:0]   ar_id_o;

   logic                      r_valid_i;
   logic                      r_ready_o;
   logic [BEAT_WIDTH-1:0]     r_data_i;
   logic                      r_last_i;
   logic [AXI_ID_WIDTH-1:0]   r_id_i;
   logic [1:0]                r_resp_i;

   logic                      rtrn_valid_o;
   logic                      rtrn_ready_i;
   logic [LINE_WIDTH-1:0]     rtrn_data_o;
   logic [TID_WIDTH-1:0]      rtrn_tid_o;
   logic                      rtrn_nc_o;
   logic                      rtrn_err_o;

   modport master (
      input  req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
      output req_ready_o,
      output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_id_o,
      input  ar_ready_i,
      input  r_valid_i, r_data_i, r_last_i, r_id_i, r_resp_i,
      output r_ready_o,
      output rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o,
      input  rtrn_ready_i
   );

   modport slave (
      output req_valid_i, req_paddr_i, req_nc_i, req_tid_i,
      input  req_ready_o,
      input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_id_o,
      output ar_ready_i,
      output r_valid_i, r_data_i, r_last_i, r_id_i, r_resp_i,
      input  r_ready_o,
      input  rtrn_valid_o, rtrn_data_o, rtrn_tid_o, rtrn_nc_o, rtrn_err_o,
      output rtrn_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/icache_refill_meta_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_meta_fifo
//  Purpose  : Small synchronous FIFO of per-request metadata, no fall-through.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_refill_meta_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      full_o   = (count_q == CNT_W'(DEPTH));
      empty_o  = (count_q == '0);
      rdata_o  = mem_q[rd_ptr_q];
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl
//  Purpose  : Turns I$ misses into AXI AR bursts and assembles R beats into
//             returned lines, with up to MAX_OUTSTANDING requests in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
   import icache_refill_pkg::*;
#(
   parameter int unsigned LINE_WIDTH      = DEF_LINE_WIDTH,
   parameter int unsigned BEAT_WIDTH      = DEF_BEAT_WIDTH,
   parameter int unsigned PADDR_WIDTH     = DEF_PADDR_WIDTH,
   parameter int unsigned AXI_ADDR_WIDTH  = DEF_AXI_ADDR_WIDTH,
   parameter int unsigned TID_WIDTH       = DEF_TID_WIDTH,
   parameter int unsigned AXI_ID_WIDTH    = DEF_AXI_ID_WIDTH,
   parameter int unsigned RD_TX_ID        = DEF_RD_TX_ID,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   icache_refill_ctrl_if.master bus,
   output logic                 busy_o
);
   localparam int unsigned NUM_BEATS = num_beats(LINE_WIDTH, BEAT_WIDTH);
   localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   logic                      ar_valid_q, ar_valid_d;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [7:0]                ar_len_q, ar_len_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic [LINE_WIDTH-1:0]     asm_q, asm_d;
   logic                      rtrn_valid_q, rtrn_valid_d;
   logic [LINE_WIDTH-1:0]     rtrn_data_q, rtrn_data_d;
   logic [TID_WIDTH-1:0]      rtrn_tid_q, rtrn_tid_d;
   logic                      rtrn_nc_q, rtrn_nc_d;
   logic                      rtrn_err_q, rtrn_err_d;

   logic  fifo_full, fifo_empty, accept, r_hs, cnt_at_end, last_beat;
   meta_t push_meta, head;
   logic  unused_resp;

   icache_refill_meta_fifo #(
      .WIDTH ($bits(meta_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_meta_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .wdata_i (push_meta),
      .pop_i   (r_hs & last_beat),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.ar_valid_o   = ar_valid_q;
   assign bus.ar_addr_o    = ar_addr_q;
   assign bus.ar_len_o     = ar_len_q;
   assign bus.ar_size_o    = 3'($clog2(BEAT_WIDTH / 8));
   assign bus.ar_id_o      = AXI_ID_WIDTH'(RD_TX_ID);
   assign bus.rtrn_valid_o = rtrn_valid_q;
   assign bus.rtrn_data_o  = rtrn_data_q;
   assign bus.rtrn_tid_o   = rtrn_tid_q;
   assign bus.rtrn_nc_o    = rtrn_nc_q;
   assign bus.rtrn_err_o   = rtrn_err_q;
   assign busy_o           = ~fifo_empty | ar_valid_q | rtrn_valid_q;
   assign unused_resp      = bus.r_resp_i[0];

   always_comb begin
      // Reset gating keeps the request port quiet while the block is held.
      bus.req_ready_o = ~rst_i & ~ar_valid_q & ~fifo_full;
      accept          = bus.req_valid_i & bus.req_ready_o;
      push_meta.tid   = bus.req_tid_i;
      push_meta.nc    = bus.req_nc_i;
      bus.r_ready_o   = ~fifo_empty & ~(rtrn_valid_q & ~bus.rtrn_ready_i);
      r_hs            = bus.r_valid_i & bus.r_ready_o;
      cnt_at_end      = (cnt_q == CNT_W'(NUM_BEATS - 1));
      last_beat       = bus.r_last_i | (~head.nc & cnt_at_end);

      ar_valid_d = ar_valid_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      if (accept) begin
         ar_valid_d = 1'b1;
         if (bus.req_nc_i) begin
            ar_addr_d = AXI_ADDR_WIDTH'(align_beat(64'(bus.req_paddr_i), BEAT_WIDTH));
            ar_len_d  = 8'd0;
         end else begin
            ar_addr_d = AXI_ADDR_WIDTH'(align_line(64'(bus.req_paddr_i), LINE_WIDTH));
            ar_len_d  = 8'(NUM_BEATS - 1);
         end
      end else if (ar_valid_q && bus.ar_ready_i) begin
         ar_valid_d = 1'b0;
      end

      cnt_d        = cnt_q;
      err_d        = err_q;
      asm_d        = asm_q;
      rtrn_valid_d = rtrn_valid_q;
      rtrn_data_d  = rtrn_data_q;
      rtrn_tid_d   = rtrn_tid_q;
      rtrn_nc_d    = rtrn_nc_q;
      rtrn_err_d   = rtrn_err_q;
      if (rtrn_valid_q && bus.rtrn_ready_i) begin
         rtrn_valid_d = 1'b0;
      end
      if (r_hs) begin
         if (head.nc) begin
            asm_d                   = '0;
            asm_d[BEAT_WIDTH-1:0]   = bus.r_data_i;
         end else begin
            for (int i = 0; i < int'(NUM_BEATS); i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  asm_d[i*BEAT_WIDTH +: BEAT_WIDTH] = bus.r_data_i;
               end
            end
         end
         if (last_beat) begin
            // Output slot loads the line including this beat; assembly restarts.
            cnt_d        = '0;
            err_d        = 1'b0;
            rtrn_valid_d = 1'b1;
            rtrn_data_d  = asm_d;
            rtrn_tid_d   = head.tid;
            rtrn_nc_d    = head.nc;
            rtrn_err_d   = err_q | bus.r_resp_i[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
            err_d = err_q | bus.r_resp_i[1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ar_valid_q   <= 1'b0;
         ar_addr_q    <= '0;
         ar_len_q     <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         asm_q        <= '0;
         rtrn_valid_q <= 1'b0;
         rtrn_data_q  <= '0;
         rtrn_tid_q   <= '0;
         rtrn_nc_q    <= 1'b0;
         rtrn_err_q   <= 1'b0;
      end else begin
         ar_valid_q   <= ar_valid_d;
         ar_addr_q    <= ar_addr_d;
         ar_len_q     <= ar_len_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         asm_q        <= asm_d;
         rtrn_valid_q <= rtrn_valid_d;
         rtrn_data_q  <= rtrn_data_d;
         rtrn_tid_q   <= rtrn_tid_d;
         rtrn_nc_q    <= rtrn_nc_d;
         rtrn_err_q   <= rtrn_err_d;
      end
   end

`ifndef SYNTHESIS
   a_r_id : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.r_valid_i |-> (bus.r_id_i == AXI_ID_WIDTH'(RD_TX_ID)));
   a_r_last : assert property (@(posedge clk_i) disable iff (rst_i)
      r_hs |-> (bus.r_last_i == (head.nc | cnt_at_end)));
   a_r_orphan : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.r_valid_i |-> !fifo_empty);
`endif
endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_icache_refill_ctrl
//  Purpose  : Directed self-checking bench for the I$ refill engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;
   import icache_refill_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic busy_o;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   icache_refill_ctrl_if bus ();

   icache_refill_ctrl dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .bus    (bus),
      .busy_o (busy_o)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts and ends on a falling edge; returns one cycle after acceptance.
   task automatic issue(input logic [55:0] pa, input logic nc, input logic [1:0] tid);
      int n = 0;
      bus.req_valid_i = 1'b1;
      bus.req_paddr_i = pa;
      bus.req_nc_i    = nc;
      bus.req_tid_i   = tid;
      #1;
      while (!bus.req_ready_o && n < 50) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      check("req_accept", bus.req_ready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
   endtask

   task automatic beat(input logic [63:0] data, input logic last, input logic [1:0] resp);
      int n = 0;
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = data;
      bus.r_last_i  = last;
      bus.r_resp_i  = resp;
      #1;
      while (!bus.r_ready_o && n < 50) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      check("r_accept", bus.r_ready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.r_valid_i = 1'b0;
      bus.r_last_i  = 1'b0;
      bus.r_resp_i  = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_i  = 1'b0;
      bus.req_paddr_i  = '0;
      bus.req_nc_i     = 1'b0;
      bus.req_tid_i    = '0;
      bus.ar_ready_i   = 1'b1;
      bus.r_valid_i    = 1'b0;
      bus.r_data_i     = '0;
      bus.r_last_i     = 1'b0;
      bus.r_id_i       = '0;
      bus.r_resp_i     = 2'b00;
      bus.rtrn_ready_i = 1'b1;

      repeat (3) @(negedge clk_i);
      check("rst_req_ready", bus.req_ready_o, 1'b0);
      check("rst_ar_valid", bus.ar_valid_o, 1'b0);
      check("rst_ar_size", bus.ar_size_o, 3'd3);
      check("rst_ar_id", bus.ar_id_o, 4'd0);
      check("rst_r_ready", bus.r_ready_o, 1'b0);
      check("rst_rtrn_valid", bus.rtrn_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      #1 check("idle_req_ready", bus.req_ready_o, 1'b1);
      @(negedge clk_i);

      // 1: cacheable two-beat line
      issue(56'h8000_1238, 1'b0, 2'd1);
      check("t1_ar_valid", bus.ar_valid_o, 1'b1);
      check("t1_ar_addr", bus.ar_addr_o, 64'h8000_1230);
      check("t1_ar_len", bus.ar_len_o, 8'd1);
      check("t1_req_ready", bus.req_ready_o, 1'b0);
      check("t1_busy", busy_o, 1'b1);
      @(negedge clk_i);
      check("t1_ar_drop", bus.ar_valid_o, 1'b0);
      beat(64'hA, 1'b0, 2'b00);
      check("t1_no_early", bus.rtrn_valid_o, 1'b0);
      beat(64'hB, 1'b1, 2'b00);
      check("t1_rtrn_valid", bus.rtrn_valid_o, 1'b1);
      check("t1_rtrn_data", bus.rtrn_data_o, {64'hB, 64'hA});
      check("t1_rtrn_tid", bus.rtrn_tid_o, 2'd1);
      check("t1_rtrn_nc", bus.rtrn_nc_o, 1'b0);
      check("t1_rtrn_err", bus.rtrn_err_o, 1'b0);
      @(negedge clk_i);
      check("t1_drained", bus.rtrn_valid_o, 1'b0);
      check("t1_idle", busy_o, 1'b0);

      // 2: non-cacheable single beat, upper slot must be cleared
      issue(56'h1004, 1'b1, 2'd0);
      check("t2_ar_addr", bus.ar_addr_o, 64'h1000);
      check("t2_ar_len", bus.ar_len_o, 8'd0);
      @(negedge clk_i);
      beat(64'hDEAD, 1'b1, 2'b00);
      check("t2_rtrn_valid", bus.rtrn_valid_o, 1'b1);
      check("t2_rtrn_data", bus.rtrn_data_o, {64'h0, 64'hDEAD});
      check("t2_rtrn_nc", bus.rtrn_nc_o, 1'b1);
      @(negedge clk_i);

      // 3: AR back-pressure
      bus.ar_ready_i = 1'b0;
      issue(56'h2008, 1'b0, 2'd2);
      for (int i = 0; i < 5; i++) begin
         check("t3_ar_hold", bus.ar_valid_o, 1'b1);
         check("t3_addr_hold", bus.ar_addr_o, 64'h2000);
         check("t3_req_block", bus.req_ready_o, 1'b0);
         @(negedge clk_i);
      end
      bus.ar_ready_i = 1'b1;
      @(negedge clk_i);
      check("t3_ar_drop", bus.ar_valid_o, 1'b0);
      @(negedge clk_i);
      check("t3_single_hs", bus.ar_valid_o, 1'b0);
      beat(64'hC, 1'b0, 2'b00);
      beat(64'hD, 1'b1, 2'b00);
      check("t3_rtrn_data", bus.rtrn_data_o, {64'hD, 64'hC});
      check("t3_rtrn_tid", bus.rtrn_tid_o, 2'd2);
      @(negedge clk_i);

      // 4: FIFO full stalls a third miss; lines return in order
      issue(56'h100, 1'b0, 2'd2);
      issue(56'h200, 1'b0, 2'd3);
      bus.req_valid_i = 1'b1;
      bus.req_paddr_i = 56'h300;
      bus.req_nc_i    = 1'b0;
      bus.req_tid_i   = 2'd0;
      @(negedge clk_i);
      #1 check("t4_full_block", bus.req_ready_o, 1'b0);
      beat(64'h1, 1'b0, 2'b00);
      check("t4_still_full", bus.req_ready_o, 1'b0);
      beat(64'h2, 1'b1, 2'b00);
      check("t4_first_tid", bus.rtrn_tid_o, 2'd2);
      check("t4_first_data", bus.rtrn_data_o, {64'h2, 64'h1});
      check("t4_slot_free", bus.req_ready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      check("t4_drained", bus.rtrn_valid_o, 1'b0);
      beat(64'h3, 1'b0, 2'b00);
      beat(64'h4, 1'b1, 2'b00);
      check("t4_second_tid", bus.rtrn_tid_o, 2'd3);
      check("t4_second_data", bus.rtrn_data_o, {64'h4, 64'h3});
      beat(64'h5, 1'b0, 2'b00);
      beat(64'h6, 1'b1, 2'b00);
      check("t4_third_tid", bus.rtrn_tid_o, 2'd0);
      check("t4_third_addr", bus.ar_addr_o, 64'h300);
      @(negedge clk_i);

      // 5: error flag on one burst only
      issue(56'h400, 1'b0, 2'd1);
      @(negedge clk_i);
      beat(64'h7, 1'b0, 2'b00);
      beat(64'h8, 1'b1, 2'b10);
      check("t5_err_set", bus.rtrn_err_o, 1'b1);
      @(negedge clk_i);
      issue(56'h500, 1'b0, 2'd2);
      @(negedge clk_i);
      beat(64'h17, 1'b0, 2'b00);
      beat(64'h18, 1'b1, 2'b00);
      check("t5_err_clear", bus.rtrn_err_o, 1'b0);
      @(negedge clk_i);

      // 6: return back-pressure, drain-and-load same cycle, mid-burst reset
      bus.rtrn_ready_i = 1'b0;
      issue(56'h600, 1'b0, 2'd1);
      @(negedge clk_i);
      beat(64'h9, 1'b0, 2'b00);
      beat(64'h10, 1'b1, 2'b00);
      check("t6_held_valid", bus.rtrn_valid_o, 1'b1);
      issue(56'h700, 1'b0, 2'd2);
      @(negedge clk_i);
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 64'h11;
      bus.r_last_i  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t6_r_stall", bus.r_ready_o, 1'b0);
         check("t6_data_hold", bus.rtrn_data_o, {64'h10, 64'h9});
         @(negedge clk_i);
      end
      bus.rtrn_ready_i = 1'b1;
      #1 check("t6_r_resume", bus.r_ready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      bus.r_valid_i = 1'b0;
      check("t6_old_drained", bus.rtrn_valid_o, 1'b0);
      issue(56'h800, 1'b1, 2'd3);
      @(negedge clk_i);
      beat(64'h12, 1'b1, 2'b00);
      check("t6_line_data", bus.rtrn_data_o, {64'h12, 64'h11});
      check("t6_line_tid", bus.rtrn_tid_o, 2'd2);
      beat(64'hEE, 1'b1, 2'b00);
      check("t6_swap_valid", bus.rtrn_valid_o, 1'b1);
      check("t6_swap_tid", bus.rtrn_tid_o, 2'd3);
      check("t6_swap_data", bus.rtrn_data_o, {64'h0, 64'hEE});
      check("t6_swap_nc", bus.rtrn_nc_o, 1'b1);
      @(negedge clk_i);

      issue(56'h900, 1'b0, 2'd1);
      @(negedge clk_i);
      beat(64'h1, 1'b0, 2'b00);
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 64'h2;
      bus.r_last_i  = 1'b1;
      rst_i         = 1'b1;
      @(negedge clk_i);
      bus.r_valid_i = 1'b0;
      bus.r_last_i  = 1'b0;
      check("t6_rst_ar_valid", bus.ar_valid_o, 1'b0);
      check("t6_rst_rtrn_valid", bus.rtrn_valid_o, 1'b0);
      check("t6_rst_r_ready", bus.r_ready_o, 1'b0);
      check("t6_rst_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("t6_post_rst_busy", busy_o, 1'b0);
      issue(56'hA00, 1'b0, 2'd2);
      @(negedge clk_i);
      beat(64'h21, 1'b0, 2'b00);
      check("t6_cnt_cleared", bus.rtrn_valid_o, 1'b0);
      beat(64'h22, 1'b1, 2'b00);
      check("t6_post_rst_data", bus.rtrn_data_o, {64'h22, 64'h21});
      check("t6_post_rst_tid", bus.rtrn_tid_o, 2'd2);
      @(negedge clk_i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Refill engine between the L1 instruction cache miss port and a simplified AXI read channel (AR/R signal bundles). It turns each miss into one AR request:
- cacheable miss: full-line burst;
- non-cacheable access: single beat.
It tracks up to MaxOutstanding in-flight requests, assembles R beats into a line, and returns it on a registered valid/ready port with the transaction ID and an error flag.

Parameters:
LineWidth, 128, I$ line width in bits; multiple of BeatWidth.
BeatWidth, 64, AXI data width in bits.
PAddrWidth, 56, physical address width.
AxiAddrWidth, 64, AR address width; zero-extend paddr.
TidWidth, 2, cache transaction ID width.
AxiIdWidth, 4, AXI ID width.
RdTxId, 0, constant AXI ID used for every AR.
MaxOutstanding, 2, in-flight request limit; power of two, >=1.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  miss request valid
req_ready_o  out  1  miss request accepted
req_paddr_i  in  PAddrWidth  miss physical address
req_nc_i  in  1  non-cacheable (single-beat) access
req_tid_i  in  TidWidth  cache transaction ID
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
ar_addr_o  out  AxiAddrWidth  AR address
ar_len_o  out  8  AR burst length minus 1
ar_size_o  out  3  log2(BeatWidth/8)
ar_id_o  out  AxiIdWidth  always RdTxId
r_valid_i  in  1  R valid
r_ready_o  out  1  R ready
r_data_i  in  BeatWidth  R data
r_last_i  in  1  R last
r_id_i  in  AxiIdWidth  R ID
r_resp_i  in  2  R response
rtrn_valid_o  out  1  assembled line valid
rtrn_ready_i  in  1  cache accepts line
rtrn_data_o  out  LineWidth  line data; a non-cacheable word sits at slot 0
rtrn_tid_o  out  TidWidth  ID of the returned request
rtrn_nc_o  out  1  returned request was non-cacheable
rtrn_err_o  out  1  any beat had r_resp_i[1]=1
busy_o  out  1  request outstanding or AR/return pending

Behaviour:
Constant: NumBeats = LineWidth/BeatWidth.

Reset:
- rst_i sampled at clk_i; overrides all other inputs.
- All outputs are 0 except ar_id_o = RdTxId and ar_size_o = constant.
- Metadata FIFO is emptied and the beat counter cleared.
- Reset mid-burst drops all in-flight state. The AXI fabric must be reset together with this block.

Request / AR:
- req_ready_o = ~ar_valid_o & ~fifo_full.
- On accept, the AR register loads in the same cycle and ar_valid_o rises the next cycle.
- Cacheable request: ar_addr_o = paddr with log2(LineWidth/8) low bits cleared; ar_len_o = NumBeats-1.
- Non-cacheable request: ar_addr_o = paddr with log2(BeatWidth/8) low bits cleared; ar_len_o = 0.
- On accept, push {tid, nc} into the metadata FIFO. The push happens at accept, before the AR handshake, so the FIFO order equals AR order.
- AR fields are held stable while ar_valid_o & ~ar_ready_i. ar_valid_o drops the cycle after the handshake.
- Because a single AXI ID is used, R responses return in order.

R / assembly:
- r_ready_o = ~fifo_empty & ~(rtrn_valid_o & ~rtrn_ready_i).
- Beat counter cnt (width clog2(NumBeats), minimum 1):
  - cacheable: beat is written to slot cnt;
  - non-cacheable: beat is written to slot 0 and the other slots are cleared.
- err_acc accumulates the OR of r_resp_i[1] across the burst.
- Handshake with r_last_i=1, or cnt==NumBeats-1 for a cacheable burst, ends the burst:
  - next cycle: rtrn_valid_o=1 with the assembled data, the FIFO head tid/nc, and rtrn_err_o = err_acc | current bit;
  - FIFO pops, cnt and err_acc clear.
- Latency: the line is visible 1 cycle after the last-beat handshake.
- rtrn_* outputs are held until rtrn_ready_i. Output and assembly registers are separate.
- Assertions (simulation only):
  - r_id_i != RdTxId;
  - r_last_i mismatched with the expected beat count;
  - R valid while the FIFO is empty.

Boundaries:
- FIFO full: no new request accepted.
- Accept and pop in the same cycle are both allowed; occupancy is unchanged.
- Counter wraps to 0 at burst end.
- A last-beat handshake while the output slot is being drained in the same cycle is legal.
- busy_o = ~fifo_empty | ar_valid_o | rtrn_valid_o.

Decomposition:
- Package icache_refill_pkg holds:
  - the metadata struct {tid, nc};
  - functions for line and beat address alignment;
  - the NumBeats derivation.
- Sub-module icache_refill_meta_fifo: depth MaxOutstanding, synchronous active-high reset, full/empty flags, fall-through disabled.

Test Plan:
1. Cacheable miss, paddr=0x8000_1238, tid=1, ar_ready_i tied high, beats 0xA,0xB, OKAY -> ar_addr_o=0x8000_1230, ar_len_o=1; rtrn_data_o={0xB,0xA}; tid=1; err=0; rtrn_valid_o 1 cycle after last beat.
2. Non-cacheable, paddr=0x1004 -> ar_addr_o=0x1000, ar_len_o=0; one beat 0xDEAD -> rtrn_data_o={0,0xDEAD}; rtrn_nc_o=1.
3. ar_ready_i low for 5 cycles -> ar_valid_o and ar_addr_o stable throughout; req_ready_o=0; single handshake.
4. Two back-to-back misses (tid 2, 3), then a third -> third stalls (req_ready_o=0) until the first line returns; lines return in order with tid 2 then 3.
5. Second beat has r_resp_i=2'b10 -> rtrn_err_o=1; the next burst returns err=0.
6. rtrn_ready_i low during the next burst's last beat -> r_ready_o=0 until drained; no data lost. rst_i mid-burst -> all outputs 0 next cycle and busy_o=0.
